dff_share_arbiter: RTL

- Round-robin arbiter and sequencer that time-shares one WIDTH-bit register (a single DFF bank) among N_REQ requesters over a valid/ready handshake.
- Sits in front of the shared state register in the masked-accelerator test designs.
- Tracks which requester owns the register contents.
- Optionally inserts a zeroing (precharge) cycle on every owner change, so one requester's data never overwrites another's directly (no cross-owner transitions in the register).

---
 rtl/dff_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 28 ++
 rtl/dff_share_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/dff_arb_pkg.sv
// Shared types and constants for the shared-register arbiter.
package dff_arb_pkg;

    // Register occupancy: EMPTY holds no owned data, FULL holds one requester's data.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Owner index width; at least one bit so the port never collapses to zero width.
    function automatic int unsigned owner_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w > 1) ? w : 1;
    endfunction

    localparam state_e      RstState  = ST_EMPTY;
    localparam logic        RstQValid = 1'b0;
    localparam int unsigned RstPtr    = 0;
    localparam int unsigned RstOwner  = 0;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first asserted request searching upward from ptr, modulo N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    int unsigned cand;

    // Scan N candidates starting at ptr; the first hit wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int k = 0; k < N; k++) begin
            cand = (32'(ptr) + unsigned'(k)) % N;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter time-sharing one WIDTH-bit register among N_REQ requesters.
// Optional macro DFF_ARB_PRECHARGE_EN inserts a zeroing cycle on every owner change.
module dff_share_arbiter
    import dff_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned OW   = owner_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   clear,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [OW-1:0]          q_owner
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    ptr_q, ptr_d;

    logic             win_any;
    logic [OW-1:0]    win_idx;
    logic             grant;
    logic             flush;
    logic             block_foreign;
    logic [WIDTH-1:0] data_arr [N_REQ];

    rr_pick #(
        .N  (N_REQ),
        .IW (OW)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .any (win_any),
        .idx (win_idx)
    );

    // Split the flat data bus into per-requester words.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            data_arr[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

`ifdef DFF_ARB_PRECHARGE_EN
    logic foreign;
    // A different requester may only load after the register has been zeroed.
    always_comb begin
        foreign       = win_any && (state_q == ST_FULL) && (win_idx != owner_q);
        block_foreign = foreign;
    end
`else
    // Owner changes load directly; no zero cycle between owners.
    always_comb begin
        block_foreign = 1'b0;
    end
`endif

    // Grant decision, ready one-hot and next-state computation.
    always_comb begin
        grant     = win_any && !rst && !clear && !block_foreign;
        flush     = clear || block_foreign;
        req_ready = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
        end

        state_d = state_q;
        q_d     = q_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (flush) begin
            // Owner and pointer survive a flush so fairness is unaffected.
            state_d = ST_EMPTY;
            q_d     = '0;
        end else if (grant) begin
            state_d = ST_FULL;
            q_d     = data_arr[win_idx];
            owner_d = win_idx;
            ptr_d   = (win_idx == OW'(N_REQ - 1)) ? '0 : win_idx + OW'(1);
        end
    end

    // State register with synchronous reset overriding clear and requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RstState;
            q_q     <= '0;
            owner_q <= OW'(RstOwner);
            ptr_q   <= OW'(RstPtr);
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign q       = q_q;
    assign q_valid = (state_q == ST_FULL) ? 1'b1 : RstQValid;
    assign q_owner = owner_q;

endmodule
